// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM status encoding, arbiter requester class,
// arbiter FSM states and the default CPU count.
package cpu_types_pkg;

  localparam int CPUS_DEFAULT = 2;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    ICLASS = 1'b0,
    DCLASS = 1'b1
  } arb_class_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: starting at ptr and walking upward with wrap,
// returns the index of the first asserted request. Purely combinational.
module rr_pick #(
  parameter int CPUS = 2,
  parameter int RR_W = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic [CPUS-1:0] req,
  input  logic [RR_W-1:0] ptr,
  output logic [RR_W-1:0] grant,
  output logic            valid
);

  logic [RR_W:0] sum;

  // Scan CPUS positions from ptr; the first hit wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    sum   = '0;
    for (int k = 0; k < CPUS; k++) begin
      sum = {1'b0, ptr} + (RR_W+1)'(k);
      if (sum >= (RR_W+1)'(CPUS)) begin
        sum = sum - (RR_W+1)'(CPUS);
      end
      if (!valid && req[sum[RR_W-1:0]]) begin
        valid = 1'b1;
        grant = sum[RR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter for per-CPU icache/dcache requesters.
// dcache beats icache; round-robin within each class; the grant is held
// across a two-word dcache block so both words reach RAM back-to-back.
//
// Wait semantics: a requester holds its request (xREN/xWEN) until its wait
// output is 0. wait is 0 only in the single cycle the RAM reports ACCESS for
// that requester, and in that cycle the load data (ramload) is valid.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = CPUS_DEFAULT,
  parameter int RR_W = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS-1:0][31:0] iaddr,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0][31:0] iload,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS-1:0][31:0] dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  logic [1:0]           ramstate
);

  // All registered arbiter state in one struct so checkers can bind to it.
  typedef struct packed {
    arb_state_t      state;
    arb_class_t      cls;
    logic            beat;
    logic [RR_W-1:0] owner;
    logic [RR_W-1:0] rr_i;
    logic [RR_W-1:0] rr_d;
  } arb_regs_t;

  arb_regs_t       q, d;
  logic [CPUS-1:0] d_req;
  logic [RR_W-1:0] i_idx, d_idx, next_ptr;
  logic            i_valid, d_valid, owner_req, access;

  assign d_req  = dREN | dWEN;
  assign access = (ramstate == ACCESS);

  // Load data is a plain broadcast of the RAM read bus.
  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};

  rr_pick #(.CPUS(CPUS), .RR_W(RR_W)) u_pick_i (
    .req(iREN), .ptr(q.rr_i), .grant(i_idx), .valid(i_valid)
  );

  rr_pick #(.CPUS(CPUS), .RR_W(RR_W)) u_pick_d (
    .req(d_req), .ptr(q.rr_d), .grant(d_idx), .valid(d_valid)
  );

  // Pointer after the current owner, wrapping modulo CPUS.
  assign next_ptr  = (q.owner == RR_W'(CPUS - 1)) ? '0 : q.owner + RR_W'(1);
  assign owner_req = (q.cls == DCLASS) ? d_req[q.owner] : iREN[q.owner];

  // Next-state and RAM port drive; outputs idle unless the owner is requesting.
  always_comb begin
    d        = q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    case (q.state)
      IDLE: begin
        d.beat = 1'b0;
        if (d_valid) begin
          d.state = GRANT;
          d.cls   = DCLASS;
          d.owner = d_idx;
        end else if (i_valid) begin
          d.state = GRANT;
          d.cls   = ICLASS;
          d.owner = i_idx;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          // Owner withdrew (e.g. end of a halt flush): release without an access.
          d.state = IDLE;
          d.beat  = 1'b0;
        end else begin
          if (q.cls == DCLASS) begin
            // Simultaneous read and write is illegal; the write wins.
            ramWEN          = dWEN[q.owner];
            ramREN          = dREN[q.owner] & ~dWEN[q.owner];
            ramaddr         = daddr[q.owner];
            ramstore        = dstore[q.owner];
            dwait[q.owner]  = ~access;
          end else begin
            ramREN          = 1'b1;
            ramaddr         = iaddr[q.owner];
            iwait[q.owner]  = ~access;
          end
          if (access) begin
            if ((q.cls == DCLASS) && !q.beat && !daddr[q.owner][2]) begin
              // Word 0 of a block: keep the grant for word 1.
              d.beat = 1'b1;
            end else begin
              d.state = IDLE;
              d.beat  = 1'b0;
              if (q.cls == DCLASS) d.rr_d = next_ptr;
              else                 d.rr_i = next_ptr;
            end
          end
        end
      end
      default: d.state = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q <= '{state: IDLE, cls: ICLASS, beat: 1'b0,
             owner: '0, rr_i: '0, rr_d: '0};
    end else begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with CPUS=2.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic             CLK;
  logic             RST;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [1:0][31:0] iload;
  logic [1:0]       dREN;
  logic [1:0]       dWEN;
  logic [1:0][31:0] daddr;
  logic [1:0][31:0] dstore;
  logic [1:0]       dwait;
  logic [1:0][31:0] dload;
  logic             ramREN;
  logic             ramWEN;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic [31:0]      ramload;
  logic [1:0]       ramstate;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.CPUS(2)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  // Clock and reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1; iREN = 2'b11; dREN = 2'b11; dWEN = 2'b00;
    iaddr[0] = 32'h0; iaddr[1] = 32'h0;
    daddr[0] = 32'h14; daddr[1] = 32'h24;
    dstore[0] = 32'h0; dstore[1] = 32'h0;
    ramstate = BUSY; ramload = 32'hCAFE0001;
    @(posedge CLK); @(posedge CLK); @(negedge CLK);
    checks++; if ({iwait, dwait} !== 4'b1111) begin errors++; $display("FAIL reset_waits got %b exp 1111", {iwait, dwait}); end
    checks++; if ({ramREN, ramWEN} !== 2'b00) begin errors++; $display("FAIL reset_en got %b exp 00", {ramREN, ramWEN}); end
    checks++; if ({ramaddr, ramstore} !== 64'h0) begin errors++; $display("FAIL reset_bus got %h exp 0", {ramaddr, ramstore}); end
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (ramaddr !== 32'h14 || ramREN !== 1'b1) begin errors++; $display("FAIL first_grant addr %h ren %b exp 14 1", ramaddr, ramREN); end
    checks++; if ({iwait, dwait} !== 4'b1111) begin errors++; $display("FAIL first_grant_busy got %b exp 1111", {iwait, dwait}); end
    ramstate = ACCESS;
    #1;
    checks++; if (dwait !== 2'b10 || dload[0] !== 32'hCAFE0001) begin errors++; $display("FAIL first_access dwait %b dload %h exp 10 cafe0001", dwait, dload[0]); end
    step();
    iREN = 2'b00; dREN = 2'b00; ramstate = FREE;
    step();
  endtask

  task automatic test_single_icache;
    iREN = 2'b01; iaddr[0] = 32'h40; ramstate = BUSY; ramload = 32'hDEADBEEF;
    @(negedge CLK);
    checks++; if (iwait !== 2'b11 || ramREN !== 1'b0) begin errors++; $display("FAIL ic_idle iwait %b ren %b exp 11 0", iwait, ramREN); end
    for (int c = 0; c < 2; c++) begin
      step();
      @(negedge CLK);
      checks++; if (ramaddr !== 32'h40 || ramREN !== 1'b1 || iwait !== 2'b11) begin errors++; $display("FAIL ic_busy%0d addr %h ren %b iwait %b exp 40 1 11", c, ramaddr, ramREN, iwait); end
    end
    step();
    ramstate = ACCESS;
    @(negedge CLK);
    checks++; if (ramaddr !== 32'h40 || iwait !== 2'b10 || iload[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL ic_access addr %h iwait %b iload %h exp 40 10 deadbeef", ramaddr, iwait, iload[0]); end
    step();
    iREN = 2'b00; ramstate = FREE;
    step();
  endtask

  task automatic test_block_lock;
    iREN = 2'b01; iaddr[0] = 32'h80; dREN = 2'b10; daddr[1] = 32'h100; ramstate = FREE;
    step();
    ramstate = ACCESS;
    @(negedge CLK);
    checks++; if (ramaddr !== 32'h100 || ramREN !== 1'b1 || dwait !== 2'b01 || iwait !== 2'b11) begin errors++; $display("FAIL blk_w0 addr %h ren %b dwait %b iwait %b exp 100 1 01 11", ramaddr, ramREN, dwait, iwait); end
    step();
    daddr[1] = 32'h104;
    @(negedge CLK);
    checks++; if (ramaddr !== 32'h104 || dwait !== 2'b01 || iwait !== 2'b11) begin errors++; $display("FAIL blk_w1 addr %h dwait %b iwait %b exp 104 01 11", ramaddr, dwait, iwait); end
    step();
    dREN = 2'b00; ramstate = FREE;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0 || iwait !== 2'b11) begin errors++; $display("FAIL blk_bubble ren %b iwait %b exp 0 11", ramREN, iwait); end
    step();
    ramstate = ACCESS;
    @(negedge CLK);
    checks++; if (ramaddr !== 32'h80 || iwait !== 2'b10 || ramREN !== 1'b1) begin errors++; $display("FAIL blk_icache addr %h iwait %b ren %b exp 80 10 1", ramaddr, iwait, ramREN); end
    step();
    iREN = 2'b00; ramstate = FREE;
    step();
  endtask

  task automatic test_round_robin;
    logic [31:0] exp_store;
    logic [1:0]  exp_wait;
    dWEN = 2'b11; daddr[0] = 32'h8; daddr[1] = 32'h8;
    dstore[0] = 32'hA0A0A0A0; dstore[1] = 32'hA1A1A1A1; ramstate = ACCESS;
    for (int g = 0; g < 3; g++) begin
      exp_store = (g % 2 == 0) ? 32'hA0A0A0A0 : 32'hA1A1A1A1;
      exp_wait  = (g % 2 == 0) ? 2'b10 : 2'b01;
      for (int b = 0; b < 2; b++) begin
        step();
        @(negedge CLK);
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== exp_store || dwait !== exp_wait) begin errors++; $display("FAIL rr_g%0d_b%0d wen %b ren %b store %h dwait %b exp 1 0 %h %b", g, b, ramWEN, ramREN, ramstore, dwait, exp_store, exp_wait); end
      end
      step();
      @(negedge CLK);
      checks++; if (ramWEN !== 1'b0 || dwait !== 2'b11) begin errors++; $display("FAIL rr_bubble%0d wen %b dwait %b exp 0 11", g, ramWEN, dwait); end
      if (g == 2) dWEN = 2'b00;
    end
    ramstate = FREE;
    step();
  endtask

  task automatic test_owner_drop;
    dREN = 2'b10; daddr[1] = 32'h104; ramstate = BUSY;
    step();
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1 || dwait !== 2'b11 || ramaddr !== 32'h104) begin errors++; $display("FAIL drop_grant ren %b dwait %b addr %h exp 1 11 104", ramREN, dwait, ramaddr); end
    step();
    dREN = 2'b00;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin errors++; $display("FAIL drop_same ren %b dwait %b exp 0 11", ramREN, dwait); end
    step();
    dREN = 2'b11; daddr[0] = 32'h204; ramstate = ACCESS;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin errors++; $display("FAIL drop_idle ren %b dwait %b exp 0 11", ramREN, dwait); end
    step();
    @(negedge CLK);
    checks++; if (dwait !== 2'b01 || ramaddr !== 32'h104) begin errors++; $display("FAIL drop_rr dwait %b addr %h exp 01 104", dwait, ramaddr); end
    step();
    dREN = 2'b00; ramstate = FREE;
    step();
  endtask

  task automatic test_error_hold;
    dREN = 2'b01; daddr[0] = 32'h204; iREN = 2'b10; iaddr[1] = 32'h300; ramstate = ERROR;
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      checks++; if (dwait !== 2'b11 || iwait !== 2'b11 || ramaddr !== 32'h204 || ramREN !== 1'b1) begin errors++; $display("FAIL err_hold%0d dwait %b iwait %b addr %h ren %b exp 11 11 204 1", c, dwait, iwait, ramaddr, ramREN); end
      step();
    end
    ramstate = ACCESS;
    @(negedge CLK);
    checks++; if (dwait !== 2'b10 || iwait !== 2'b11) begin errors++; $display("FAIL err_access dwait %b iwait %b exp 10 11", dwait, iwait); end
    step();
    dREN = 2'b00; ramstate = FREE;
    step();
    ramstate = ACCESS;
    @(negedge CLK);
    checks++; if (iwait !== 2'b01 || ramaddr !== 32'h300) begin errors++; $display("FAIL err_next iwait %b addr %h exp 01 300", iwait, ramaddr); end
    step();
    iREN = 2'b00; ramstate = FREE;
    step();
  endtask

  initial begin
    test_reset();
    test_single_icache();
    test_block_lock();
    test_round_robin();
    test_owner_drop();
    test_error_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the per-CPU instruction and data caches.
- Arbitrates their single-word RAM requests onto the one shared RAM port.
- Returns per-requester wait signals and load data.
- Holds the grant across a data-cache two-word block transfer, so word 0 and word 1 of a block (and of a dirty-block writeback) reach RAM back-to-back with no interleaving.

Parameters:
- CPUS, 2, number of CPUs (1..4); each CPU has one icache and one dcache requester.
- RR_W, $clog2(CPUS) (minimum 1), width of the round-robin pointers.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- iREN  in  CPUS  icache read request, per CPU
- iaddr  in  CPUS x 32  icache word address
- iwait  out  CPUS  icache stall; 0 only in the completing cycle
- iload  out  CPUS x 32  icache read data (ramload broadcast)
- dREN  in  CPUS  dcache read request
- dWEN  in  CPUS  dcache write request
- daddr  in  CPUS x 32  dcache word address
- dstore  in  CPUS x 32  dcache write data
- dwait  out  CPUS  dcache stall; 0 only in the completing cycle
- dload  out  CPUS x 32  dcache read data (ramload broadcast)
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- State machine: IDLE, GRANT.
- Registered state: owner index, owner class (I/D), beat (0/1), rr_i, rr_d.

Reset:
- state=IDLE, beat=0, rr_i=0, rr_d=0.
- All iwait/dwait=1; ramREN=ramWEN=0; ramaddr=ramstore=0.
- RST asserted mid-transfer aborts it; RAM enables drop the following cycle.

IDLE:
- RAM enables are 0 and all waits are 1.
- If any request is present:
  - Any dREN|dWEN beats any iREN.
  - Within a class, start from that class's rr pointer and pick the first requester.
  - Register the owner; next state is GRANT with beat=0.
- dREN and dWEN both high from the same CPU is illegal; treat it as a write.

GRANT:
- RAM port driven combinationally from the owner: ramREN/ramWEN, address, store.
- The owner's wait equals (ramstate != ACCESS), combinationally in the same cycle.
- All other waits stay 1.
- FREE, BUSY and ERROR all hold the grant; no timeout.
- On ACCESS:
  - dcache owner, beat=0, daddr[2]=0: stay in GRANT with beat=1 (block lock).
  - Otherwise: go to IDLE, beat=0, and advance the class rr pointer to owner+1, wrapping modulo CPUS.
- Owner drops its request while in GRANT (e.g. halt flush ends): go to IDLE next cycle with no RAM enable asserted that cycle. rr does not advance.
- Beat-1 address is not checked; the dcache is responsible for presenting daddr[2]=1.

Latency and fairness:
- Minimum latency is 1 arbitration cycle plus RAM latency.
- One idle bubble cycle between grants.
- A lone requester is served every other RAM access at best.
- Starvation bound: an icache waits only while dcache requests are continuously present. dcache requesters are round-robin fair.

Data:
- iload[c] and dload[c] equal ramload for all c, unconditionally.
- No width arithmetic beyond the rr wrap.

Decomposition:
- Shared package cpu_types_pkg gains:
  - ramstate_t enum {FREE, BUSY, ACCESS, ERROR}
  - arb_class_t enum {ICLASS, DCLASS}
  - a CPUS default constant.
- Sub-module rr_pick: parameterized CPUS.
  - Inputs: request vector, pointer.
  - Outputs: grant index, valid.
  - Purely combinational.
  - Instantiated twice, once for icache and once for dcache.

Test Plan:
1. Reset with all requests high and RST=1 for 2 cycles -> all waits=1, ramREN=ramWEN=0. First grant goes to dcache 0 on the cycle after RST falls.
2. Only iREN[0], iaddr=0x40, RAM ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF -> ramaddr=0x40 for 3 cycles. iwait[0]=0 only on the ACCESS cycle, with iload[0]=0xDEADBEEF.
3. dREN[1] on 0x100 then 0x104, with iREN[0] held high -> two consecutive GRANT accesses to 0x100 and 0x104. iwait[0] stays 1 until both complete, then the icache is served.
4. dWEN[0] and dWEN[1] both continuously requesting single words at 0x8, rr_d=0 -> grants alternate CPU0, CPU1, CPU0. The pointer wraps from 1 to 0.
5. dcache owner drops dREN mid-GRANT while ramstate=BUSY -> IDLE next cycle, no ACCESS consumed, rr_d unchanged.
6. ramstate=ERROR for 5 cycles then ACCESS -> owner wait stays 1 throughout and falls only on the ACCESS cycle. No other requester is granted meanwhile.
